alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares one extended ALU (operand muxes plus ALU core) between two requesters, for example the execute stage (port 0) and the branch/address unit (port 1). Arbitration is round-robin. The block latches the winner's operands and mux selects, drives the ALU for one cycle, registers the result and the four flags, and returns them with the owner's ID. It sits between the requesters and the ALU. It is the only driver of the ALU operand inputs and of `SEL_OP`.

## Interface
Parameters:
- `WIDTH`, default 32: data width of operands and result.

Ports:
- `clk`  input  1  system clock. All state changes on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `reqN_valid` (N=0,1)  input  1  requester N has an operation pending.
- `reqN_ack` (N=0,1)  output  1  combinational. Operands are sampled on this edge.
- `reqN_rs1`, `reqN_rs2`, `reqN_imm`, `reqN_pc`  input  `WIDTH`  requester N operands.
- `reqN_srcA_SEL`, `reqN_srcB_SEL`  input  1  requester N mux selects (1 = PC / imm).
- `reqN_SEL_OP`  input  4  requester N ALU opcode.
- `alu_RS1_data`, `alu_RS2_data`, `alu_imm`, `alu_PC`  output  `WIDTH`  registered operands to the ALU.
- `alu_srcA_SEL`, `alu_srcB_SEL`  output  1  registered mux selects to the ALU.
- `alu_SEL_OP`  output  4  registered opcode to the ALU.
- `alu_Resultado`  input  `WIDTH`  ALU result (combinational from the `alu_*` outputs).
- `alu_flagC`, `alu_flagZ`, `alu_flagError`, `alu_flagNegativo`  input  1  ALU flags.
- `rsp_valid`  output  1  one-cycle response strobe.
- `rsp_id`  output  1  requester that owns the response.
- `rsp_result`  output  `WIDTH`  registered ALU result.
- `rsp_flags`  output  4  registered flags as {C, Z, Error, Negativo}.
- `busy`  output  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE.**
  - If any `reqN_valid` is high, grant one requester.
    - Exactly one valid: grant it.
    - Both valid: grant the requester that is not `last_grant`.
  - Assert `reqN_ack` for the granted requester in the same cycle.
  - On that edge:
    - Latch its operands, selects and opcode into the `alu_*` registers.
    - Record `owner`.
    - Set `last_grant <= granted`.
    - Go to EXEC.
- **EXEC.**
  - The `alu_*` outputs are stable, so the ALU settles combinationally.
  - At the edge, capture `alu_Resultado` into `rsp_result` and the flags into `rsp_flags`.
  - `rsp_id <= owner`, `rsp_valid <= 1`, go to RESP.
- **RESP.**
  - `rsp_valid` is high for exactly this cycle.
  - At the edge: `rsp_valid <= 0`, go to IDLE.
- `reqN_ack` is 0 in EXEC and RESP.
- Requesters must hold `valid` and all operands stable until ack. The arbiter never drops an asserted request.
- The `alu_*` registers hold their last values after an operation. They change only on an ack edge.
- `rsp_result`, `rsp_flags` and `rsp_id` hold after RESP until the next EXEC capture.
- No arithmetic is done in this block. Result and flags pass through bit-exact at `WIDTH`.
- **Reset:**
  - State goes to IDLE; `rsp_valid`, `busy`, both `reqN_ack`, and all `alu_*` / `rsp_*` registers go to 0.
  - `last_grant` resets to 1, so port 0 wins the first contention.
- **Reset mid-operation** (in EXEC or RESP): the in-flight response is discarded and no `rsp_valid` pulse is emitted. The requester has already seen its ack and must reissue.
- `reqN_ack` is forced to 0 in any cycle where `rst` is high.

## Timing
- Ack in cycle T (IDLE). ALU inputs are valid in T+1 (EXEC). `rsp_valid` is high in T+2 (RESP).
- Next ack is possible in T+3. Peak throughput is one operation per 3 cycles.
- Latency from ack to response is 2 cycles, fixed and independent of opcode.
- `reqN_valid` rising during EXEC/RESP is served at the next IDLE cycle, with no additional wait.
- Continuous contention alternates strictly 0,1,0,1,…
- Single-requester streaming: one ack every 3 cycles with no gaps.
- The ALU path must close within one clock period (`alu_*` register to `rsp_*` register).

## Test plan
- **Reset values:** `rst` high for 2 cycles → all outputs 0, `busy` = 0. With both `reqN_valid` high on the first cycle after reset, `req0_ack` = 1.
- **Single op:** `req0` with rs1=5, rs2=3, `SEL_OP`=4'h0, selects 0, and an ALU stub returning 8 with Z=0 → `alu_RS1_data`=5, `alu_RS2_data`=3 in T+1. In T+2: `rsp_valid`=1, `rsp_id`=0, `rsp_result`=8, `rsp_flags`=4'b0000.
- **Mux/flag passthrough:** `req1` with `srcA_SEL`=1, `srcB_SEL`=1, pc=32'h100, imm=4, and a stub returning 32'h104 with C=1, Z=0, Error=0, Negativo=0 → `alu_srcA_SEL`=1 and `alu_srcB_SEL`=1 in EXEC; `rsp_flags`=4'b1000, `rsp_id`=1.
- **Contention:** both valid continuously for 12 cycles → acks at cycles 0,3,6,9 go to ports 0,1,0,1, with exactly 4 `rsp_valid` pulses carrying matching IDs.
- **Reset mid-op:** `rst` asserted in the EXEC cycle → no `rsp_valid` pulse, state is IDLE the next cycle, `last_grant` = 1.
- **Hold:** `req0_valid` asserted during RESP → ack in the following IDLE cycle. `alu_*` values are unchanged between operations while idle.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Bundle between the two requesters, the shared ALU and the response consumer.
// The arbiter connects through the slave modport; the environment (requesters,
// ALU core and response sink) connects through the master modport.
`timescale 1ns/1ps
interface alu_share_arbiter_if #(parameter int WIDTH = 32);
   logic             req0_valid, req1_valid;
   logic             req0_ack, req1_ack;
   logic [WIDTH-1:0] req0_rs1, req0_rs2, req0_imm, req0_pc;
   logic [WIDTH-1:0] req1_rs1, req1_rs2, req1_imm, req1_pc;
   logic             req0_srcA_SEL, req0_srcB_SEL, req1_srcA_SEL, req1_srcB_SEL;
   logic [3:0]       req0_SEL_OP, req1_SEL_OP;

   logic [WIDTH-1:0] alu_RS1_data, alu_RS2_data, alu_imm, alu_PC;
   logic             alu_srcA_SEL, alu_srcB_SEL;
   logic [3:0]       alu_SEL_OP;
   logic [WIDTH-1:0] alu_Resultado;
   logic             alu_flagC, alu_flagZ, alu_flagError, alu_flagNegativo;

   logic             rsp_valid, rsp_id;
   logic [WIDTH-1:0] rsp_result;
   logic [3:0]       rsp_flags;
   logic             busy;

   modport slave (
      input  req0_valid, req1_valid,
      output req0_ack, req1_ack,
      input  req0_rs1, req0_rs2, req0_imm, req0_pc,
      input  req1_rs1, req1_rs2, req1_imm, req1_pc,
      input  req0_srcA_SEL, req0_srcB_SEL, req1_srcA_SEL, req1_srcB_SEL,
      input  req0_SEL_OP, req1_SEL_OP,
      output alu_RS1_data, alu_RS2_data, alu_imm, alu_PC,
      output alu_srcA_SEL, alu_srcB_SEL, alu_SEL_OP,
      input  alu_Resultado, alu_flagC, alu_flagZ, alu_flagError, alu_flagNegativo,
      output rsp_valid, rsp_id, rsp_result, rsp_flags, busy
   );

   modport master (
      output req0_valid, req1_valid,
      input  req0_ack, req1_ack,
      output req0_rs1, req0_rs2, req0_imm, req0_pc,
      output req1_rs1, req1_rs2, req1_imm, req1_pc,
      output req0_srcA_SEL, req0_srcB_SEL, req1_srcA_SEL, req1_srcB_SEL,
      output req0_SEL_OP, req1_SEL_OP,
      input  alu_RS1_data, alu_RS2_data, alu_imm, alu_PC,
      input  alu_srcA_SEL, alu_srcB_SEL, alu_SEL_OP,
      output alu_Resultado, alu_flagC, alu_flagZ, alu_flagError, alu_flagNegativo,
      input  rsp_valid, rsp_id, rsp_result, rsp_flags, busy
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters. Each granted
// operation takes three cycles: ack/latch, ALU evaluate, response strobe.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a request; grant and latch operands on the ack edge
//   EXEC  | alu_* registers stable, ALU settles; capture result and flags
//   RESP  | rsp_valid high for this single cycle
`timescale 1ns/1ps
module alu_share_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   alu_share_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   logic             last_grant;
   logic             owner;
   logic             any_valid;
   logic             grant_id;
   logic             grant_en;

   logic [WIDTH-1:0] sel_rs1, sel_rs2, sel_imm, sel_pc;
   logic             sel_src_a, sel_src_b;
   logic [3:0]       sel_op;

   logic [WIDTH-1:0] alu_rs1_q, alu_rs2_q, alu_imm_q, alu_pc_q;
   logic             alu_src_a_q, alu_src_b_q;
   logic [3:0]       alu_op_q;
   logic             rsp_valid_q, rsp_id_q;
   logic [WIDTH-1:0] rsp_result_q;
   logic [3:0]       rsp_flags_q;

   // Pick the winner: a lone requester always wins, on contention the port
   // that did not win last time. Ack is suppressed while reset is asserted.
   always_comb begin
      any_valid = bus.req0_valid | bus.req1_valid;
      grant_id  = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
      grant_en  = ~rst & (state == IDLE) & any_valid;

      sel_rs1   = grant_id ? bus.req1_rs1       : bus.req0_rs1;
      sel_rs2   = grant_id ? bus.req1_rs2       : bus.req0_rs2;
      sel_imm   = grant_id ? bus.req1_imm       : bus.req0_imm;
      sel_pc    = grant_id ? bus.req1_pc        : bus.req0_pc;
      sel_src_a = grant_id ? bus.req1_srcA_SEL  : bus.req0_srcA_SEL;
      sel_src_b = grant_id ? bus.req1_srcB_SEL  : bus.req0_srcB_SEL;
      sel_op    = grant_id ? bus.req1_SEL_OP    : bus.req0_SEL_OP;
   end

   assign bus.req0_ack = grant_en & ~grant_id;
   assign bus.req1_ack = grant_en &  grant_id;

   // Sequencer: operand latch on ack, result capture in EXEC, one-cycle strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         last_grant   <= 1'b1;
         owner        <= 1'b0;
         alu_rs1_q    <= '0;
         alu_rs2_q    <= '0;
         alu_imm_q    <= '0;
         alu_pc_q     <= '0;
         alu_src_a_q  <= 1'b0;
         alu_src_b_q  <= 1'b0;
         alu_op_q     <= 4'h0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_flags_q  <= 4'h0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_en) begin
                  alu_rs1_q   <= sel_rs1;
                  alu_rs2_q   <= sel_rs2;
                  alu_imm_q   <= sel_imm;
                  alu_pc_q    <= sel_pc;
                  alu_src_a_q <= sel_src_a;
                  alu_src_b_q <= sel_src_b;
                  alu_op_q    <= sel_op;
                  owner       <= grant_id;
                  last_grant  <= grant_id;
                  state       <= EXEC;
               end
            end
            EXEC: begin
               rsp_result_q <= bus.alu_Resultado;
               rsp_flags_q  <= {bus.alu_flagC, bus.alu_flagZ,
                                bus.alu_flagError, bus.alu_flagNegativo};
               rsp_id_q     <= owner;
               rsp_valid_q  <= 1'b1;
               state        <= RESP;
            end
            RESP: begin
               rsp_valid_q <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               rsp_valid_q <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.alu_RS1_data = alu_rs1_q;
   assign bus.alu_RS2_data = alu_rs2_q;
   assign bus.alu_imm      = alu_imm_q;
   assign bus.alu_PC       = alu_pc_q;
   assign bus.alu_srcA_SEL = alu_src_a_q;
   assign bus.alu_srcB_SEL = alu_src_b_q;
   assign bus.alu_SEL_OP   = alu_op_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_id       = rsp_id_q;
   assign bus.rsp_result   = rsp_result_q;
   assign bus.rsp_flags    = rsp_flags_q;
   assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: ALU stub, directed vector table, hand-written
// multi-cycle sequences and a randomized run against a cycle-timing model.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_share_arbiter_if #(.WIDTH(W)) bus ();
   alu_share_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic [W-1:0] r;
      logic [3:0]   f;
   } alu_out_t;

   typedef struct {
      logic         valid;
      logic [W-1:0] rs1, rs2, imm, pc;
      logic         sa, sb;
      logic [3:0]   op;
   } req_t;

   typedef struct {
      int           port;
      logic [W-1:0] rs1, rs2, imm, pc;
      logic         sa, sb;
      logic [3:0]   op;
      logic         ovr;
      logic [3:0]   ovr_f;
      logic [W-1:0] exp_r;
      logic [3:0]   exp_f;
   } vec_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   req_t rq [2];
   logic       ovr_en = 1'b0;
   logic [3:0] ovr_flags = 4'h0;
   alu_out_t   stub;

   // Behavioural ALU: add, sub, and, or, xor; other opcodes flag an error.
   function automatic alu_out_t alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
      alu_out_t o;
      logic [W:0] t;
      logic err;
      err = 1'b0;
      t   = '0;
      o.r = '0;
      case (op)
         4'd0: begin t = {1'b0, a} + {1'b0, b}; o.r = t[W-1:0]; end
         4'd1: begin o.r = a - b; t[W] = (a < b); end
         4'd2: o.r = a & b;
         4'd3: o.r = a | b;
         4'd4: o.r = a ^ b;
         default: err = 1'b1;
      endcase
      o.f = {t[W], (o.r == '0), err, o.r[W-1]};
      return o;
   endfunction

   // ALU stub fed by the arbiter's registered operands.
   always_comb begin
      stub = alu_fn(bus.alu_SEL_OP,
                    bus.alu_srcA_SEL ? bus.alu_PC  : bus.alu_RS1_data,
                    bus.alu_srcB_SEL ? bus.alu_imm : bus.alu_RS2_data);
      if (ovr_en) stub.f = ovr_flags;
   end
   assign bus.alu_Resultado = stub.r;
   assign {bus.alu_flagC, bus.alu_flagZ, bus.alu_flagError, bus.alu_flagNegativo} = stub.f;

   // Requester array onto the interface.
   always_comb begin
      bus.req0_valid    = rq[0].valid;  bus.req1_valid    = rq[1].valid;
      bus.req0_rs1      = rq[0].rs1;    bus.req1_rs1      = rq[1].rs1;
      bus.req0_rs2      = rq[0].rs2;    bus.req1_rs2      = rq[1].rs2;
      bus.req0_imm      = rq[0].imm;    bus.req1_imm      = rq[1].imm;
      bus.req0_pc       = rq[0].pc;     bus.req1_pc       = rq[1].pc;
      bus.req0_srcA_SEL = rq[0].sa;     bus.req1_srcA_SEL = rq[1].sa;
      bus.req0_srcB_SEL = rq[0].sb;     bus.req1_srcB_SEL = rq[1].sb;
      bus.req0_SEL_OP   = rq[0].op;     bus.req1_SEL_OP   = rq[1].op;
   end

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   function automatic logic [W-1:0] acks();
      return {{(W-2){1'b0}}, bus.req1_ack, bus.req0_ack};
   endfunction

   function automatic logic [W-1:0] onehot(input int p);
      return (p == 0) ? 32'd1 : 32'd2;
   endfunction

   task automatic new_req(input int i);
      rq[i].rs1 = $urandom;
      rq[i].rs2 = $urandom;
      rq[i].imm = $urandom;
      rq[i].pc  = $urandom;
      rq[i].sa  = 1'($urandom_range(0, 1));
      rq[i].sb  = 1'($urandom_range(0, 1));
      rq[i].op  = 4'($urandom_range(0, 5));
   endtask

   task automatic chk_alu(input string nm, input req_t r);
      chk({nm, " alu_RS1"},  bus.alu_RS1_data, r.rs1);
      chk({nm, " alu_RS2"},  bus.alu_RS2_data, r.rs2);
      chk({nm, " alu_imm"},  bus.alu_imm,      r.imm);
      chk({nm, " alu_PC"},   bus.alu_PC,       r.pc);
      chk({nm, " alu_srcA"}, 32'(bus.alu_srcA_SEL), 32'(r.sa));
      chk({nm, " alu_srcB"}, 32'(bus.alu_srcB_SEL), 32'(r.sb));
      chk({nm, " alu_op"},   32'(bus.alu_SEL_OP),   32'(r.op));
   endtask

   vec_t vt [7];

   task automatic run_vec(input int k);
      vec_t v;
      int   p;
      v = vt[k];
      p = v.port;
      rq[p].rs1 = v.rs1; rq[p].rs2 = v.rs2; rq[p].imm = v.imm; rq[p].pc = v.pc;
      rq[p].sa = v.sa; rq[p].sb = v.sb; rq[p].op = v.op; rq[p].valid = 1'b1;
      ovr_en = v.ovr; ovr_flags = v.ovr_f;
      smp();
      chk($sformatf("vec%0d ack", k), acks(), onehot(p));
      chk($sformatf("vec%0d busy_idle", k), 32'(bus.busy), 32'd0);
      next_cyc();
      rq[p].valid = 1'b0;
      smp();
      chk_alu($sformatf("vec%0d", k), rq[p]);
      chk($sformatf("vec%0d busy_exec", k), 32'(bus.busy), 32'd1);
      chk($sformatf("vec%0d ack_exec", k), acks(), 32'd0);
      next_cyc();
      smp();
      chk($sformatf("vec%0d rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("vec%0d rsp_id", k), 32'(bus.rsp_id), 32'(p));
      chk($sformatf("vec%0d rsp_result", k), bus.rsp_result, v.exp_r);
      chk($sformatf("vec%0d rsp_flags", k), 32'(bus.rsp_flags), 32'(v.exp_f));
      next_cyc();
      smp();
      chk($sformatf("vec%0d rsp_drop", k), 32'(bus.rsp_valid), 32'd0);
      chk($sformatf("vec%0d result_hold", k), bus.rsp_result, v.exp_r);
      ovr_en = 1'b0;
      next_cyc();
   endtask

   initial begin
      int       rsp_cnt;
      int       exp_port;
      req_t     hold_req;
      int       next_free, last_win, win, p_cyc;
      logic     pv;
      int       p_port;
      req_t     p_req;
      alu_out_t p_exp;
      logic [1:0] exp_ack;

      // port | rs1 | rs2 | imm | pc | srcA | srcB | op | ovr | ovr_f | result | flags{C,Z,E,N}
      vt[0] = '{0, 32'd5,          32'd3,          32'd0,      32'd0,          1'b0, 1'b0, 4'h0, 1'b0, 4'h0,    32'd8,          4'b0000};
      vt[1] = '{1, 32'd0,          32'd0,          32'd4,      32'h100,        1'b1, 1'b1, 4'h0, 1'b1, 4'b1000, 32'h104,        4'b1000};
      vt[2] = '{0, 32'hFFFF_FFFF,  32'd1,          32'd0,      32'd0,          1'b0, 1'b0, 4'h0, 1'b0, 4'h0,    32'd0,          4'b1100};
      vt[3] = '{1, 32'd3,          32'd5,          32'd0,      32'd0,          1'b0, 1'b0, 4'h1, 1'b0, 4'h0,    32'hFFFF_FFFE,  4'b1001};
      vt[4] = '{0, 32'h0000_F0F0,  32'h0000_DEAD,  32'h0FF0,   32'd0,          1'b0, 1'b1, 4'h2, 1'b0, 4'h0,    32'h0000_00F0,  4'b0000};
      vt[5] = '{1, 32'h0000_1234,  32'd1,          32'd0,      32'd0,          1'b0, 1'b0, 4'hF, 1'b0, 4'h0,    32'd0,          4'b0110};
      vt[6] = '{0, 32'h0000_1111,  32'd0,          32'd0,      32'h8000_0000,  1'b1, 1'b0, 4'h3, 1'b0, 4'h0,    32'h8000_0000,  4'b0001};

      for (int i = 0; i < 2; i++) begin
         rq[i] = '{1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 4'h0};
      end

      // Reset values; ack forced low while reset is high even with requests.
      rst = 1'b1;
      next_cyc();
      rq[0].valid = 1'b1;
      rq[1].valid = 1'b1;
      smp();
      chk("reset ack", acks(), 32'd0);
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("reset rsp_result", bus.rsp_result, 32'd0);
      chk("reset rsp_flags", 32'(bus.rsp_flags), 32'd0);
      chk("reset alu_RS1", bus.alu_RS1_data, 32'd0);
      chk("reset alu_PC", bus.alu_PC, 32'd0);
      chk("reset alu_op", 32'(bus.alu_SEL_OP), 32'd0);
      chk("reset alu_srcA", 32'(bus.alu_srcA_SEL), 32'd0);
      next_cyc();
      rst = 1'b0;
      smp();
      chk("first contention ack", acks(), 32'd1);
      next_cyc();
      rq[0].valid = 1'b0;
      rq[1].valid = 1'b0;
      repeat (3) next_cyc();

      // Directed vector table.
      for (int k = 0; k < 7; k++) run_vec(k);

      // Continuous contention for 12 cycles, starting from reset.
      rst = 1'b1;
      next_cyc();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         new_req(i);
         rq[i].valid = 1'b1;
      end
      rsp_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         smp();
         exp_port = (c / 3) % 2;
         chk($sformatf("contend c%0d ack", c), acks(), (c % 3 == 0) ? onehot(exp_port) : 32'd0);
         chk($sformatf("contend c%0d rsp_valid", c), 32'(bus.rsp_valid), (c % 3 == 2) ? 32'd1 : 32'd0);
         if (bus.rsp_valid) begin
            rsp_cnt++;
            chk($sformatf("contend c%0d rsp_id", c), 32'(bus.rsp_id), 32'(exp_port));
         end
         next_cyc();
      end
      rq[0].valid = 1'b0;
      rq[1].valid = 1'b0;
      chk("contend rsp pulses", 32'(rsp_cnt), 32'd4);

      // Reset during EXEC: response discarded, port 0 wins next contention.
      rq[0].rs1 = 32'h77; rq[0].valid = 1'b1;
      smp();
      chk("midrst ack", acks(), 32'd1);
      next_cyc();
      rq[0].valid = 1'b0;
      rst = 1'b1;
      smp();
      chk("midrst exec rsp_valid", 32'(bus.rsp_valid), 32'd0);
      next_cyc();
      rst = 1'b0;
      rq[0].valid = 1'b1;
      rq[1].valid = 1'b1;
      smp();
      chk("midrst no pulse", 32'(bus.rsp_valid), 32'd0);
      chk("midrst idle", 32'(bus.busy), 32'd0);
      chk("midrst last_grant", acks(), 32'd1);
      next_cyc();
      rq[0].valid = 1'b0;
      rq[1].valid = 1'b0;
      repeat (3) next_cyc();

      // Request rising during RESP is served in the very next IDLE cycle;
      // alu_* registers hold while idle.
      rq[0].rs1 = 32'hAAAA; rq[0].rs2 = 32'h1; rq[0].op = 4'h0;
      rq[0].sa = 1'b0; rq[0].sb = 1'b0; rq[0].valid = 1'b1;
      next_cyc();
      rq[0].valid = 1'b0;
      next_cyc();
      rq[0].rs1 = 32'h5555; rq[0].rs2 = 32'h2; rq[0].imm = 32'h9; rq[0].pc = 32'h40;
      rq[0].op = 4'h4; rq[0].valid = 1'b1;
      smp();
      chk("hold resp ack", acks(), 32'd0);
      chk("hold resp rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold resp result", bus.rsp_result, 32'hAAAB);
      next_cyc();
      smp();
      chk("hold idle ack", acks(), 32'd1);
      hold_req = rq[0];
      next_cyc();
      rq[0].valid = 1'b0;
      next_cyc();
      next_cyc();
      for (int c = 0; c < 4; c++) begin
         new_req(0);
         new_req(1);
         smp();
         chk_alu($sformatf("idle hold c%0d", c), hold_req);
         chk($sformatf("idle hold c%0d result", c), bus.rsp_result, 32'h5557);
         next_cyc();
      end

      // Randomized run against a timing model: the block accepts a request
      // whenever three cycles have passed since its previous ack.
      rst = 1'b1;
      next_cyc();
      rst = 1'b0;
      rq[0].valid = 1'b0;
      rq[1].valid = 1'b0;
      next_free = 0;
      last_win  = 1;
      pv        = 1'b0;
      p_cyc     = 0;
      p_port    = 0;
      p_req     = rq[0];
      p_exp     = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         smp();
         exp_ack = 2'b00;
         chk("rand busy", 32'(bus.busy), (cyc < next_free) ? 32'd1 : 32'd0);
         if (pv && cyc == p_cyc + 1) chk_alu("rand", p_req);
         if (pv && cyc == p_cyc + 2) begin
            chk("rand rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("rand rsp_id", 32'(bus.rsp_id), 32'(p_port));
            chk("rand rsp_result", bus.rsp_result, p_exp.r);
            chk("rand rsp_flags", 32'(bus.rsp_flags), 32'(p_exp.f));
            pv = 1'b0;
         end else begin
            chk("rand rsp_idle", 32'(bus.rsp_valid), 32'd0);
         end
         if (cyc >= next_free && (rq[0].valid || rq[1].valid)) begin
            if (rq[0].valid && rq[1].valid) win = 1 - last_win;
            else win = rq[1].valid ? 1 : 0;
            exp_ack[win] = 1'b1;
            last_win  = win;
            next_free = cyc + 3;
            pv        = 1'b1;
            p_cyc     = cyc;
            p_port    = win;
            p_req     = rq[win];
            p_exp     = alu_fn(p_req.op, p_req.sa ? p_req.pc : p_req.rs1,
                               p_req.sb ? p_req.imm : p_req.rs2);
         end
         chk("rand ack", acks(), 32'(exp_ack));
         next_cyc();
         for (int i = 0; i < 2; i++) begin
            if (exp_ack[i]) begin
               rq[i].valid = 1'($urandom_range(0, 1));
               if (rq[i].valid) new_req(i);
            end else if (!rq[i].valid && $urandom_range(0, 1) == 1) begin
               new_req(i);
               rq[i].valid = 1'b1;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
